// File: rtl/branch_predict_ctrl.sv
// Branch predictor and redirect controller: 2-bit saturating counter table
// indexed by PC, combinational fetch prediction, EX-stage resolution with
// one-shot redirect/flush sequencing that holds through pipeline stalls.
module branch_predict_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             if_is_branch,
  input  logic [WIDTH-1:0] if_target,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_next_pc,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             stall,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int unsigned IDX_BITS = $clog2(BHT_ENTRIES);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t              state;
  logic [1:0]          bht [BHT_ENTRIES];
  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                accept;
  logic                mispredict;

  assign if_idx     = if_pc[IDX_BITS+1:2];
  assign ex_idx     = ex_pc[IDX_BITS+1:2];
  assign accept     = ex_valid & ~stall & (state == IDLE);
  assign mispredict = ex_taken ^ ex_pred_taken;

  // Fetch-side prediction; reads the registered table so a same-cycle update
  // is only visible from the following cycle.
  always_comb begin
    pred_taken   = if_is_branch & bht[if_idx][1];
    pred_next_pc = pred_taken ? if_target : (if_pc + WIDTH'(4));
  end

  // Saturating counter update for each accepted resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // Redirect FSM with registered redirect/flush/redirect_pc outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mispredict) begin
            state       <= REDIRECT;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            redirect_pc <= ex_taken ? ex_target : (ex_pc + WIDTH'(4));
          end
        end
        REDIRECT: begin
          if (!stall) begin
            state    <= IDLE;
            redirect <= 1'b0;
            flush    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          redirect <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating resolution and misprediction statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept) begin
      if (branch_count != '1) branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and redirect controller for the five-stage RV32I pipeline. It holds a table of 2-bit saturating counters indexed by PC and gives the fetch stage a taken/not-taken prediction for predecoded conditional branches. When a branch resolves in EX, it updates the table. On a misprediction, it sequences a one-shot PC redirect and an IF/ID + ID/EX flush that honours pipeline stalls.

## Interface
- WIDTH, 32, address/data width
- BHT_ENTRIES, 16, number of counters; power of two, ≥2; IDX_BITS = $clog2(BHT_ENTRIES)
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  WIDTH  PC of instruction in fetch
- if_is_branch  in  1  fetch predecode: instruction is B-type
- if_target  in  WIDTH  predecoded target (if_pc + B-imm)
- pred_taken  out  1  prediction for current fetch
- pred_next_pc  out  WIDTH  next fetch PC chosen by predictor
- ex_valid  in  1  a B-type instruction is resolving in EX this cycle
- ex_pc  in  WIDTH  PC of resolving branch
- ex_taken  in  1  actual outcome (branch comparator pc_sel)
- ex_pred_taken  in  1  prediction carried down the pipeline with the branch
- ex_target  in  WIDTH  resolved target
- stall  in  1  pipeline stall; EX contents held
- redirect  out  1  PC must load redirect_pc
- redirect_pc  out  WIDTH  corrected fetch PC
- flush  out  1  kill IF/ID and ID/EX
- branch_count  out  32  resolved branches, saturating
- mispredict_count  out  32  mispredictions, saturating

## Operation
- Index: idx(pc) = pc[IDX_BITS+1:2].
- Prediction (combinational): pred_taken = if_is_branch & bht[idx(if_pc)][1]. pred_next_pc = pred_taken ? if_target : if_pc+4 (mod 2^WIDTH).
- Resolution accept: a resolution is accepted at a rising edge when ex_valid=1, stall=0 and state=IDLE.
- Table update on accept:
  - ex_taken=1: the counter increments, saturating at 2'b11.
  - ex_taken=0: the counter decrements, saturating at 2'b00.
- Mispredict: ex_taken != ex_pred_taken.
- On an accepted mispredict, the block enters state REDIRECT.
  - redirect_pc is latched as ex_taken ? ex_target : ex_pc+4.
- FSM states: IDLE, REDIRECT.
  - IDLE → REDIRECT on an accepted mispredict; otherwise it stays in IDLE.
  - REDIRECT → IDLE at the first edge with stall=0.
  - While stall=1, REDIRECT holds with its outputs unchanged.
- redirect = flush = (state==REDIRECT).
- ex_valid is ignored while in REDIRECT: no table update, no counter change. The instruction in EX at that point is a wrong-path bubble.
- Counters on accept:
  - branch_count +1.
  - mispredict_count +1 if mispredicted.
  - Both saturate at 32'hFFFF_FFFF.
- Read/write collision: a fetch read and an EX update to the same index in the same cycle return the pre-update value. The new value is visible from the next cycle.

## Timing
- Reset (rst_n=0, async): all bht entries = 2'b01 (weakly not-taken), state=IDLE, redirect=0, flush=0, redirect_pc=0, branch_count=0, mispredict_count=0.
- pred_taken and pred_next_pc are combinational: zero latency from if_pc, if_is_branch and if_target.
- redirect and flush are registered:
  - They assert in the cycle after the accepting edge.
  - Width is exactly one cycle when stall=0, and they extend for every stalled cycle.
- A correctly predicted branch produces no redirect or flush.
- Back-to-back branches: a branch accepted the cycle after a REDIRECT cycle is processed normally.
- Reset mid-REDIRECT drops redirect and flush immediately (async). The table returns to 2'b01.
- stall=1 blocks acceptance. A branch held in EX is accepted once, at the first unstalled edge.

## Test plan
- Reset, then if_pc=0x40, if_is_branch=1, if_target=0x80 → pred_taken=0, pred_next_pc=0x44; all outputs and counters 0.
- Two accepted taken resolutions at ex_pc=0x40, ex_target=0x80, with ex_pred_taken=0 on the first → one cycle of redirect=flush=1 with redirect_pc=0x80. Afterwards pred_taken=1 for if_pc=0x40; branch_count=2, mispredict_count=1.
- Five taken resolutions followed by one not-taken at the same index → counter saturates at 3 and then reads 2; pred_taken stays 1.
- Mispredict accepted with ex_taken=0, ex_pc=0x100, then stall=1 for 3 cycles → redirect=flush=1 for 4 cycles, redirect_pc=0x104. ex_valid=1 during REDIRECT changes nothing.
- Same-cycle fetch read and EX update at index 5, counter initially 1 → pred_taken=0 in that cycle and 1 in the next cycle.
- Assert rst_n=0 during REDIRECT → redirect=0 asynchronously; table returns to 2'b01 and counters return to 0.
